ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx_if.sv | 24 ++
 rtl/ps2_host_tx.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// Host-to-device PS/2 transmit bundle: command handshake, raw line levels and
// open-drain enables. The slave modport is the transmitter's view.
interface ps2_host_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_ack_err;
  logic       tx_timeout;

  modport slave (
    input  tx_start, tx_data, ps2_clk_in, ps2_data_in,
    output ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_ack_err, tx_timeout
  );

  modport master (
    output tx_start, tx_data, ps2_clk_in, ps2_data_in,
    input  ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_ack_err, tx_timeout
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, start, 8 data LSB-first,
// odd parity, stop, ACK). Define PS2_TX_TIMEOUT_EN to add the line watchdog.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic          clk,
  input  logic          rst,
  ps2_host_tx_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, START, SHIFT, PARITY, STOP, ACK, WAIT_IDLE
  } state_t;

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [INH_W-1:0] inh_cnt_reg, inh_cnt_next;
  logic [2:0]       bit_cnt_reg, bit_cnt_next;
  logic [7:0]       data_reg, data_next;
  logic             parity_reg, parity_next;
  logic             ack_lat_reg, ack_lat_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             ack_err_reg, ack_err_next;
  logic             clk_oe_reg, clk_oe_next;
  logic             data_oe_reg, data_oe_next;
  logic             timeout_next;

  // Index 0 = PS/2 clock, index 1 = PS/2 data; both idle high.
  logic [1:0] line_in;
  logic [1:0] sync_meta_reg;
  logic [1:0] sync_reg;
  logic       clk_prev_reg;
  logic       clk_sync, data_sync, fall;

  assign line_in = {bus.ps2_data_in, bus.ps2_clk_in};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_meta_reg[gi] <= 1'b1;
          sync_reg[gi]      <= 1'b1;
        end else begin
          sync_meta_reg[gi] <= line_in[gi];
          sync_reg[gi]      <= sync_meta_reg[gi];
        end
      end
    end
  endgenerate

  assign clk_sync  = sync_reg[0];
  assign data_sync = sync_reg[1];
  assign fall      = clk_prev_reg & ~clk_sync;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;
  logic            timeout_reg;
  logic            wd_active;

  assign wd_active = (state_reg != IDLE) && (state_reg != INHIBIT);
`endif

  always_comb begin
    state_next   = state_reg;
    inh_cnt_next = inh_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    data_next    = data_reg;
    parity_next  = parity_reg;
    ack_lat_next = ack_lat_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    ack_err_next = 1'b0;
    timeout_next = 1'b0;
    clk_oe_next  = 1'b0;
    data_oe_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.tx_start) begin
          data_next    = bus.tx_data;
          parity_next  = ~^bus.tx_data;
          inh_cnt_next = '0;
          bit_cnt_next = '0;
          ack_lat_next = 1'b0;
          busy_next    = 1'b1;
          state_next   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt_reg == INH_LAST) state_next = START;
        else inh_cnt_next = inh_cnt_reg + INH_W'(1);
      end
      START: if (fall) state_next = SHIFT;
      SHIFT: begin
        if (fall) begin
          if (bit_cnt_reg == 3'd7) state_next = PARITY;
          else bit_cnt_next = bit_cnt_reg + 3'd1;
        end
      end
      PARITY: if (fall) state_next = STOP;
      STOP: begin
        // Edge 11: the device holds data low to acknowledge.
        if (fall) begin
          ack_lat_next = data_sync;
          state_next   = ACK;
        end
      end
      ACK: if (clk_sync) state_next = WAIT_IDLE;
      WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          done_next    = 1'b1;
          ack_err_next = ack_lat_reg;
          busy_next    = 1'b0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    wd_cnt_next = (!wd_active || fall) ? '0 : wd_cnt_reg + WD_W'(1);
    if (wd_active && (wd_cnt_reg == WD_LAST)) begin
      done_next    = 1'b1;
      ack_err_next = 1'b0;
      timeout_next = 1'b1;
      busy_next    = 1'b0;
      state_next   = IDLE;
    end
`endif

    // Line enables are registered from the next state so the pads never glitch.
    case (state_next)
      INHIBIT: begin
        clk_oe_next  = 1'b1;
        data_oe_next = (inh_cnt_next == INH_LAST);
      end
      START:   data_oe_next = 1'b1;
      SHIFT:   data_oe_next = ~data_next[bit_cnt_next];
      PARITY:  data_oe_next = ~parity_next;
      default: data_oe_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      inh_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      data_reg     <= '0;
      parity_reg   <= 1'b0;
      ack_lat_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      ack_err_reg  <= 1'b0;
      clk_oe_reg   <= 1'b0;
      data_oe_reg  <= 1'b0;
      clk_prev_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      inh_cnt_reg  <= inh_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      data_reg     <= data_next;
      parity_reg   <= parity_next;
      ack_lat_reg  <= ack_lat_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      ack_err_reg  <= ack_err_next;
      clk_oe_reg   <= clk_oe_next;
      data_oe_reg  <= data_oe_next;
      clk_prev_reg <= clk_sync;
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      wd_cnt_reg  <= wd_cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  assign bus.tx_timeout = timeout_reg;
`else
  // Always 0; written as a parameter expression so the watchdog limit stays referenced.
  assign bus.tx_timeout = (TIMEOUT_CYCLES < 0) & timeout_next;
`endif

  assign bus.ps2_clk_oe  = clk_oe_reg;
  assign bus.ps2_data_oe = data_oe_reg;
  assign bus.tx_busy     = busy_reg;
  assign bus.tx_done     = done_reg;
  assign bus.tx_ack_err  = ack_err_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: an open-drain PS/2 device model clocks the
// frame out and records line bits; expected frames are hand-computed constants.
module tb_ps2_host_tx;

  localparam int HALF    = 20;
  localparam int INHIBIT = 10000;
  localparam int TIMEOUT = 2000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_host_tx_if bus ();

  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;
  assign bus.ps2_clk_in  = dev_clk  & ~bus.ps2_clk_oe;
  assign bus.ps2_data_in = dev_data & ~bus.ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INHIBIT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle-level monitor of the DUT outputs, sampled on the falling edge.
  int   cyc = 0;
  int   done_total = 0, err_total = 0, to_total = 0;
  int   done_run = 0, last_done_width = 0, oe_run = 0, last_oe_run = 0;
  int   done_cyc = 0, last_fall_cyc = 0;
  logic err_at_done = 0, to_at_done = 0, busy_at_done = 0, busy_prev_at_done = 0;
  logic oe_at_done = 0, busy_prev = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.tx_done) begin
      done_total++;
      done_cyc          = cyc;
      err_at_done       = bus.tx_ack_err;
      to_at_done        = bus.tx_timeout;
      busy_at_done      = bus.tx_busy;
      busy_prev_at_done = busy_prev;
      oe_at_done        = bus.ps2_clk_oe | bus.ps2_data_oe;
      done_run++;
    end else begin
      if (done_run != 0) last_done_width = done_run;
      done_run = 0;
    end
    if (bus.tx_ack_err) err_total++;
    if (bus.tx_timeout) to_total++;
    if (bus.ps2_clk_oe) oe_run++;
    else begin
      if (oe_run != 0) last_oe_run = oe_run;
      oe_run = 0;
    end
    busy_prev = bus.tx_busy;
  end

  task automatic start_tx(input logic [7:0] d, input string tag);
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    check_val({tag, "_busy_set"}, bus.tx_busy, 1);
  endtask

  // Device side: wait for request-to-send, then clock nedges falling edges,
  // sampling the line just before each falling edge.
  task automatic dev_xfer(input int nedges, input bit ack, output logic [10:0] bits);
    int t = 0;
    bits = '0;
    while (!(bus.ps2_clk_oe == 1'b0 && bus.ps2_data_oe == 1'b1) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check_val("rts_seen", (t < 20000), 1);
    for (int k = 0; k < nedges; k++) begin
      repeat (HALF) @(negedge clk);
      bits[k] = bus.ps2_data_in;
      if (k == 10 && ack) begin
        dev_data = 1'b0;
        repeat (2) @(negedge clk);
      end
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk);
    dev_data = 1'b1;
  endtask

  task automatic wait_done(input int d0, input int budget, input string tag);
    int t = 0;
    while (done_total == d0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check_val({tag, "_done_seen"}, (done_total != d0), 1);
  endtask

  task automatic run_xfer(input logic [7:0] d, input bit ack, input logic [10:0] exp_bits,
                          input bit exp_err, input int glitch_at, input string tag);
    int d0 = done_total;
    int e0 = err_total;
    logic [10:0] bits;
    start_tx(d, tag);
    if (glitch_at > 0) begin
      repeat (glitch_at - 1) @(negedge clk);
      bus.tx_data  = 8'hAA;
      bus.tx_start = 1'b1;
      @(negedge clk);
      bus.tx_start = 1'b0;
    end
    dev_xfer(11, ack, bits);
    wait_done(d0, 2000, tag);
    repeat (3) @(negedge clk);
    $display("xfer %s data=%02h line_bits(k0..k10 as [0..10])=%b done=%0d ack_err=%0b inhibit=%0d",
             tag, d, bits, done_total - d0, err_at_done, last_oe_run);
    check_val({tag, "_bits"}, bits, exp_bits);
    check_val({tag, "_done_cnt"}, done_total - d0, 1);
    check_val({tag, "_err_at_done"}, err_at_done, exp_err);
    check_val({tag, "_err_cnt"}, err_total - e0, exp_err);
    check_val({tag, "_busy_at_done"}, busy_at_done, 0);
    check_val({tag, "_busy_before_done"}, busy_prev_at_done, 1);
    check_val({tag, "_done_width"}, last_done_width, 1);
    check_val({tag, "_inhibit_len"}, last_oe_run, INHIBIT);
    check_val({tag, "_oe_at_done"}, oe_at_done, 0);
  endtask

  initial begin
    logic [10:0] bits;
    int d0;
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;

    repeat (3) @(negedge clk);
    check_val("rst_clk_oe", bus.ps2_clk_oe, 0);
    check_val("rst_data_oe", bus.ps2_data_oe, 0);
    check_val("rst_busy", bus.tx_busy, 0);
    check_val("rst_done", bus.tx_done, 0);
    check_val("rst_ack_err", bus.tx_ack_err, 0);
    check_val("rst_timeout", bus.tx_timeout, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_val("idle_no_done", done_total, 0);
    check_val("idle_busy", bus.tx_busy, 0);

    // Frames as {stop, parity, data[7:0], start}, bit k = k-th line bit.
    run_xfer(8'hF4, 1'b1, 11'b10111101000, 1'b0, 0, "f4");
    run_xfer(8'h00, 1'b1, 11'b11000000000, 1'b0, 0, "x00");
    run_xfer(8'hFF, 1'b1, 11'b11111111110, 1'b0, 0, "xff");
    run_xfer(8'h55, 1'b0, 11'b11010101010, 1'b1, 0, "nack");
    run_xfer(8'hF4, 1'b1, 11'b10111101000, 1'b0, 50, "inh_ign");
    repeat (100) @(negedge clk);
    check_val("inh_ign_no_requeue", bus.tx_busy, 0);
    check_val("inh_ign_clk_free", bus.ps2_clk_oe, 0);

    // Reset in the middle of the data bits: 0x12 bit3 = 0 so data is pulled low.
    d0 = done_total;
    start_tx(8'h12, "rst_mid");
    dev_xfer(4, 1'b0, bits);
    check_val("rst_mid_data_pulled", bus.ps2_data_oe, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_val("rst_mid_clk_oe", bus.ps2_clk_oe, 0);
    check_val("rst_mid_data_oe", bus.ps2_data_oe, 0);
    check_val("rst_mid_busy", bus.tx_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    check_val("rst_mid_no_done", done_total - d0, 0);
    run_xfer(8'hF4, 1'b1, 11'b10111101000, 1'b0, 0, "after_rst");

`ifdef PS2_TX_TIMEOUT_EN
    d0 = done_total;
    start_tx(8'hF4, "wdog");
    dev_xfer(5, 1'b0, bits);
    wait_done(d0, TIMEOUT + 1000, "wdog");
    $display("xfer wdog data=f4 edges=5 timeout=%0b latency=%0d", to_at_done, done_cyc - last_fall_cyc);
    check_val("wdog_timeout_flag", to_at_done, 1);
    check_val("wdog_err_clear", err_at_done, 0);
    check_val("wdog_oe_released", oe_at_done, 0);
    check_val("wdog_latency_ok",
              (done_cyc - last_fall_cyc >= TIMEOUT) && (done_cyc - last_fall_cyc <= TIMEOUT + 8), 1);
`else
    check_val("no_timeout_pulses", to_total, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
